// File: rtl/wb_stage.sv
// RV32I write-back stage: load alignment, write-back select, 32x32 register file with
// write-through read ports, and a one-cycle-delayed commit copy. Optional macro: WB_INSTRET_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_ld_wb,
    input  logic [2:0]  ld_code_wb,
    input  logic [4:0]  rd_adr_wb,
    input  logic [31:0] rd_data_wb,
    input  logic        wbk_rd_reg_wb,
    input  logic [31:0] ld_data_wb,
    input  logic        stall,
    input  logic        rst_pipe,
    input  logic [4:0]  rs1_adr_id,
    input  logic [4:0]  rs2_adr_id,
    output logic [31:0] rs1_data_id,
    output logic [31:0] rs2_data_id,
    output logic        wbk_en_wb,
    output logic [4:0]  wbk_adr_wb,
    output logic [31:0] wbk_data_wb,
    output logic        wbk_en_wbd,
    output logic [4:0]  wbk_adr_wbd,
    output logic [31:0] wbk_data_wbd,
    output logic [63:0] instret
);

    logic [1:0]  ofs;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_aligned;

    logic [31:0] rf_q [1:31];
    logic        en_wbd_q;
    logic [4:0]  adr_wbd_q;
    logic [31:0] data_wbd_q;

    assign ofs = rd_data_wb[1:0];

    always_comb begin
        ld_byte = ld_data_wb[7:0];
        case (ofs)
            2'd1:    ld_byte = ld_data_wb[15:8];
            2'd2:    ld_byte = ld_data_wb[23:16];
            2'd3:    ld_byte = ld_data_wb[31:24];
            default: ld_byte = ld_data_wb[7:0];
        endcase
        ld_half = ofs[1] ? ld_data_wb[31:16] : ld_data_wb[15:0];
        case (ld_code_wb)
            3'b000:  ld_aligned = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_aligned = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_aligned = ld_data_wb;
            3'b100:  ld_aligned = {24'd0, ld_byte};
            3'b101:  ld_aligned = {16'd0, ld_half};
            default: ld_aligned = 32'd0;
        endcase
    end

    assign wbk_data_wb = cmd_ld_wb ? ld_aligned : rd_data_wb;
    assign wbk_adr_wb  = rd_adr_wb;
    assign wbk_en_wb   = wbk_rd_reg_wb & ~stall & ~rst_pipe & (rd_adr_wb != 5'd0);

    // x0 has no storage; wbk_en_wb already excludes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (wbk_en_wb) begin
            rf_q[rd_adr_wb] <= wbk_data_wb;
        end
    end

    // Bypass the in-flight commit; outputs forced to 0 while reset is held
    always_comb begin
        rs1_data_id = 32'd0;
        if (rst_n && rs1_adr_id != 5'd0) begin
            if (wbk_en_wb && rs1_adr_id == rd_adr_wb) rs1_data_id = wbk_data_wb;
            else                                      rs1_data_id = rf_q[rs1_adr_id];
        end
    end

    always_comb begin
        rs2_data_id = 32'd0;
        if (rst_n && rs2_adr_id != 5'd0) begin
            if (wbk_en_wb && rs2_adr_id == rd_adr_wb) rs2_data_id = wbk_data_wb;
            else                                      rs2_data_id = rf_q[rs2_adr_id];
        end
    end

    // wbk_en_wb is already low under rst_pipe, so the delayed enable drops with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_wbd_q   <= 1'b0;
            adr_wbd_q  <= 5'd0;
            data_wbd_q <= 32'd0;
        end else begin
            en_wbd_q   <= wbk_en_wb;
            adr_wbd_q  <= wbk_adr_wb;
            data_wbd_q <= wbk_data_wb;
        end
    end

    assign wbk_en_wbd   = en_wbd_q;
    assign wbk_adr_wbd  = adr_wbd_q;
    assign wbk_data_wbd = data_wbd_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         instret_q <= 64'd0;
        else if (wbk_en_wb) instret_q <= instret_q + 64'd1;
    end

    assign instret = instret_q;
`else
    assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; expected values are hand-computed.
// Honors WB_INSTRET_EN the same way the design does.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        cmd_ld_wb;
    logic [2:0]  ld_code_wb;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb;
    logic        wbk_rd_reg_wb;
    logic [31:0] ld_data_wb;
    logic        stall;
    logic        rst_pipe;
    logic [4:0]  rs1_adr_id;
    logic [4:0]  rs2_adr_id;
    logic [31:0] rs1_data_id;
    logic [31:0] rs2_data_id;
    logic        wbk_en_wb;
    logic [4:0]  wbk_adr_wb;
    logic [31:0] wbk_data_wb;
    logic        wbk_en_wbd;
    logic [4:0]  wbk_adr_wbd;
    logic [31:0] wbk_data_wbd;
    logic [63:0] instret;

    int total;
    int bad;
    int commits;

    wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_ld_wb    (cmd_ld_wb),
        .ld_code_wb   (ld_code_wb),
        .rd_adr_wb    (rd_adr_wb),
        .rd_data_wb   (rd_data_wb),
        .wbk_rd_reg_wb(wbk_rd_reg_wb),
        .ld_data_wb   (ld_data_wb),
        .stall        (stall),
        .rst_pipe     (rst_pipe),
        .rs1_adr_id   (rs1_adr_id),
        .rs2_adr_id   (rs2_adr_id),
        .rs1_data_id  (rs1_data_id),
        .rs2_data_id  (rs2_data_id),
        .wbk_en_wb    (wbk_en_wb),
        .wbk_adr_wb   (wbk_adr_wb),
        .wbk_data_wb  (wbk_data_wb),
        .wbk_en_wbd   (wbk_en_wbd),
        .wbk_adr_wbd  (wbk_adr_wbd),
        .wbk_data_wbd (wbk_data_wbd),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic ld, input logic [2:0] code, input logic [4:0] rd,
                          input logic [31:0] data, input logic wr, input logic [31:0] ldw);
        cmd_ld_wb     = ld;
        ld_code_wb    = code;
        rd_adr_wb     = rd;
        rd_data_wb    = data;
        wbk_rd_reg_wb = wr;
        ld_data_wb    = ldw;
        #1;
    endtask

    function automatic logic [63:0] exp_ir(input int n);
`ifdef WB_INSTRET_EN
        return 64'(n);
`else
        return 64'd0;
`endif
    endfunction

    initial begin
        total = 0; bad = 0; commits = 0;
        rst_n = 1'b0; stall = 1'b0; rst_pipe = 1'b0;
        rs1_adr_id = 5'd5; rs2_adr_id = 5'd0;
        set_wb(1'b0, 3'b000, 5'd5, 32'h0000_0077, 1'b1, 32'd0);
        #2;
        // reset state, including a would-be bypass that must read 0
        check("rst_rs1", rs1_data_id, 32'd0);
        check("rst_en_wbd", wbk_en_wbd, 1'b0);
        check("rst_adr_wbd", wbk_adr_wbd, 5'd0);
        check("rst_data_wbd", wbk_data_wbd, 32'd0);
        check("rst_instret", instret, 64'd0);
        wbk_rd_reg_wb = 1'b0;
        #4 rst_n = 1'b1;
        tick();

        // LB at ofs 3
        set_wb(1'b1, 3'b000, 5'd5, 32'h0000_0003, 1'b1, 32'h80FF_7F01);
        check("lb_data", wbk_data_wb, 32'hFFFF_FF80);
        check("lb_en", wbk_en_wb, 1'b1);
        check("lb_bypass", rs1_data_id, 32'hFFFF_FF80);
        tick(); commits++;
        set_wb(1'b1, 3'b100, 5'd5, 32'h0000_0001, 1'b0, 32'h80FF_7F01);
        check("lb_array", rs1_data_id, 32'hFFFF_FF80);
        check("lbu_ofs1", wbk_data_wb, 32'h0000_007F);
        check("lb_en_wbd", wbk_en_wbd, 1'b1);

        // halfword, word and invalid code
        set_wb(1'b1, 3'b001, 5'd6, 32'h0000_0002, 1'b0, 32'h8001_7FFE);
        check("lh_ofs2", wbk_data_wb, 32'hFFFF_8001);
        set_wb(1'b1, 3'b101, 5'd6, 32'h0000_0000, 1'b0, 32'h8001_7FFE);
        check("lhu_ofs0", wbk_data_wb, 32'h0000_7FFE);
        set_wb(1'b1, 3'b101, 5'd6, 32'h0000_0003, 1'b0, 32'h8001_7FFE);
        check("lhu_ofs3", wbk_data_wb, 32'h0000_8001);
        set_wb(1'b1, 3'b010, 5'd6, 32'h0000_0003, 1'b0, 32'h8001_7FFE);
        check("lw", wbk_data_wb, 32'h8001_7FFE);
        set_wb(1'b1, 3'b011, 5'd6, 32'h0000_0000, 1'b0, 32'h8001_7FFE);
        check("ld_bad_code", wbk_data_wb, 32'd0);

        // dual-port bypass
        rs1_adr_id = 5'd7; rs2_adr_id = 5'd7;
        set_wb(1'b0, 3'b010, 5'd7, 32'h0000_1234, 1'b1, 32'hFFFF_FFFF);
        check("byp_rs1", rs1_data_id, 32'h0000_1234);
        check("byp_rs2", rs2_data_id, 32'h0000_1234);
        check("byp_adr", wbk_adr_wb, 5'd7);
        tick(); commits++;
        set_wb(1'b0, 3'b010, 5'd7, 32'h0000_9999, 1'b0, 32'd0);
        check("arr_rs1", rs1_data_id, 32'h0000_1234);
        check("arr_rs2", rs2_data_id, 32'h0000_1234);

        // x0 write
        rs1_adr_id = 5'd0;
        set_wb(1'b0, 3'b000, 5'd0, 32'h0000_DEAD, 1'b1, 32'd0);
        check("x0_en", wbk_en_wb, 1'b0);
        check("x0_rs1", rs1_data_id, 32'd0);
        tick();
        check("x0_en_wbd", wbk_en_wbd, 1'b0);
        check("x0_rs1_after", rs1_data_id, 32'd0);

        // stall for 3 cycles, then one commit
        rs1_adr_id = 5'd9;
        stall = 1'b1;
        set_wb(1'b0, 3'b000, 5'd9, 32'h0000_0055, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("stall_en", wbk_en_wb, 1'b0);
            tick();
        end
        check("stall_rs1", rs1_data_id, 32'd0);
        check("stall_instret", instret, exp_ir(commits));
        stall = 1'b0; #1;
        check("unstall_en", wbk_en_wb, 1'b1);
        tick(); commits++;
        wbk_rd_reg_wb = 1'b0; #1;
        check("unstall_rs1", rs1_data_id, 32'h0000_0055);
        check("unstall_instret", instret, exp_ir(commits));

        // flush drops the write; delayed adr/data still follow
        rst_pipe = 1'b1;
        set_wb(1'b0, 3'b000, 5'd9, 32'h0000_0066, 1'b1, 32'd0);
        check("flush_en", wbk_en_wb, 1'b0);
        tick();
        check("flush_en_wbd", wbk_en_wbd, 1'b0);
        check("flush_adr_wbd", wbk_adr_wbd, 5'd9);
        check("flush_data_wbd", wbk_data_wbd, 32'h0000_0066);
        rst_pipe = 1'b0;
        wbk_rd_reg_wb = 1'b0; #1;
        check("flush_rs1", rs1_data_id, 32'h0000_0055);
        check("flush_instret", instret, exp_ir(commits));

        // back-to-back commits through the delayed copy
        set_wb(1'b0, 3'b000, 5'd3, 32'd5, 1'b1, 32'd0);
        tick(); commits++;
        check("d1_en", wbk_en_wbd, 1'b1);
        check("d1_adr", wbk_adr_wbd, 5'd3);
        check("d1_data", wbk_data_wbd, 32'd5);
        set_wb(1'b0, 3'b000, 5'd4, 32'd9, 1'b1, 32'd0);
        tick(); commits++;
        check("d2_en", wbk_en_wbd, 1'b1);
        check("d2_adr", wbk_adr_wbd, 5'd4);
        check("d2_data", wbk_data_wbd, 32'd9);

        // ten commits, then asynchronous reset mid-cycle
        for (int i = 0; i < 10; i++) begin
            set_wb(1'b0, 3'b000, 5'(10 + i), 32'(17 * (i + 1)), 1'b1, 32'd0);
            tick(); commits++;
        end
        rs1_adr_id = 5'd10; rs2_adr_id = 5'd19;
        set_wb(1'b0, 3'b000, 5'd12, 32'h0000_0BAD, 1'b0, 32'd0);
        check("pre_rst_rs1", rs1_data_id, 32'd17);
        check("pre_rst_rs2", rs2_data_id, 32'd170);
        check("pre_rst_instret", instret, exp_ir(commits));
        wbk_rd_reg_wb = 1'b1; rd_adr_wb = 5'd10;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rs1", rs1_data_id, 32'd0);
        check("mid_rst_rs2", rs2_data_id, 32'd0);
        check("mid_rst_en_wbd", wbk_en_wbd, 1'b0);
        check("mid_rst_adr_wbd", wbk_adr_wbd, 5'd0);
        check("mid_rst_data_wbd", wbk_data_wbd, 32'd0);
        check("mid_rst_instret", instret, 64'd0);
        wbk_rd_reg_wb = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_rs1", rs1_data_id, 32'd0);
        check("post_rst_rs2", rs2_data_id, 32'd0);
        check("post_rst_instret", instret, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the RV32I pipeline, directly downstream of the memory-access stage. It takes the registered MA→WB bundle and the raw load word, then aligns and sign- or zero-extends load data. It selects the write-back value, commits it to the integrated 32×32 integer register file, and serves the two ID-stage read ports with write-through bypass. It also keeps a one-cycle-delayed copy of the commit so that the EX forwarding logic can cover the write→read hazard window.

## Interface
Parameters:
- none (register file fixed at 32 entries × 32 bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_ld_wb  in  1  instruction in WB is a load
- ld_code_wb  in  3  funct3 of the load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd_adr_wb  in  5  destination register
- rd_data_wb  in  32  ALU result; for loads this is the effective address (bits [1:0] give the byte offset)
- wbk_rd_reg_wb  in  1  instruction writes rd
- ld_data_wb  in  32  raw 32-bit word read from the data RAM or IO
- stall  in  1  pipeline stall; no commit while high
- rst_pipe  in  1  pipeline flush; no commit while high
- rs1_adr_id, rs2_adr_id  in  5 each  ID-stage read addresses
- rs1_data_id, rs2_data_id  out  32 each  read data (combinational)
- wbk_en_wb  out  1  commit this cycle (combinational)
- wbk_adr_wb  out  5  equal to rd_adr_wb
- wbk_data_wb  out  32  value being committed (combinational)
- wbk_en_wbd  out  1  registered copy of wbk_en_wb
- wbk_adr_wbd  out  5  registered copy of wbk_adr_wb
- wbk_data_wbd  out  32  registered copy of wbk_data_wb
- instret  out  64  retired write-back counter (see Configuration)

## Operation
- Load aligner; ofs = rd_data_wb[1:0]:
  - LB/LBU: byte = ld_data_wb[8*ofs+7 : 8*ofs], sign- or zero-extended.
  - LH/LHU: half = ofs[1] ? [31:16] : [15:0], extended; ofs[0] is ignored.
  - LW: whole word; ofs is ignored.
  - Any other code: 32'd0.
- wbk_data_wb = cmd_ld_wb ? aligned load : rd_data_wb.
- wbk_en_wb = wbk_rd_reg_wb & ~stall & ~rst_pipe & (rd_adr_wb != 0).
- Register file:
  - Writes at posedge clk when wbk_en_wb is high.
  - x0 is never stored and always reads 0.
- Read port, per port:
  - Address 0 returns 0.
  - Else if wbk_en_wb is high and the address equals rd_adr_wb, returns wbk_data_wb (write-through bypass).
  - Else returns the stored value.
  - Both ports may bypass the same write simultaneously.
- Delayed copy:
  - Each cycle, wbk_*_wbd <= wbk_*_wb.
  - On rst_pipe, wbk_en_wbd <= 0; wbk_adr_wbd and wbk_data_wbd still update.
- Stall: an instruction held in WB during a stall commits exactly once, in the first cycle stall is low.
- rst_pipe together with a valid write: the write is dropped.

## Timing
- Load alignment, write-back mux, wbk_en_wb and read data are combinational from the inputs within the same cycle.
- The register file update becomes visible through the array one cycle after the commit edge; the bypass covers the commit cycle itself.
- *_wbd outputs lag the *_wb outputs by exactly one cycle.
- Reset values:
  - All 31 registers = 0.
  - wbk_en_wbd = 0, wbk_adr_wbd = 0, wbk_data_wbd = 0, instret = 0.
  - rs1_data_id and rs2_data_id read 0 during reset.
- Reset asserted mid-operation clears the above state immediately (asynchronous); any commit pending at that moment is lost.

## Configuration
- Macro WB_INSTRET_EN, defined:
  - instret increments by 1 at every posedge where wbk_en_wb is high.
  - Wraps from 2^64−1 to 0.
  - Held through stall; not cleared by rst_pipe.
- Macro WB_INSTRET_EN, undefined:
  - No counter flops.
  - instret is tied to 64'd0.

## Test plan
- LB/LBU sign handling: ld_data_wb = 32'h80FF7F01, rd_data_wb[1:0] = 3, rd = x5.
  - LB → x5 = 32'hFFFFFF80.
  - LBU at ofs = 1 → 32'h0000007F.
- LH/LHU/LW and invalid code: ld_data_wb = 32'h8001_7FFE.
  - LH at ofs = 2 → 32'hFFFF8001.
  - LHU at ofs = 0 → 32'h00007FFE.
  - LW → 32'h80017FFE.
  - Code 3'b011 → 0.
- Bypass and x0:
  - Commit x7 = 32'h1234 while rs1_adr_id = rs2_adr_id = 7 → both ports read 32'h1234 that cycle, and again the next cycle from the array.
  - Write x0 = 32'hDEAD → reads 0; wbk_en_wb = 0.
- Stall and flush:
  - Hold a write valid with stall = 1 for 3 cycles, then release → exactly one commit; instret += 1.
  - Same write with rst_pipe = 1 → no commit; wbk_en_wbd = 0 next cycle.
- Delayed copy: commit x3 = 5, then x4 = 9 on consecutive cycles → wbd shows (1, x3, 5) then (1, x4, 9), one cycle late.
- Reset mid-run: assert rst_n low after 10 commits → registers, wbd outputs and instret read 0 immediately; with WB_INSTRET_EN undefined, instret stays 0 throughout.
